// File: rtl/fetch_stage.sv
// Purpose : RV32I instruction fetch; owns the PC, issues single-outstanding imem reads, fills IF/ID.
// Latency : request accepted in N, rvalid in N+1, IF/ID valid (and next request) in N+2.
// Backpressure: StallD holds IF/ID; a word that arrives during a stall waits in a one-entry skid buffer.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   PCSrc, PCTarget       redirect from execute (also flushes IF/ID)
//   StallD                decode not accepting; IF/ID holds while it carries a real instruction
//   imem_req/addr/ready   request handshake (address is the PC, word aligned)
//   imem_rvalid/rdata     in-order response, at most one outstanding
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register outputs
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] PC_ALIGN = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ,   // request to PC on the bus
    S_WAIT,  // request accepted, response pending
    S_HOLD,  // response parked in skid buffer until decode accepts
    S_DROP   // response pending but squashed by a redirect
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        accept;
  logic        load;
  logic [31:0] load_word;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  assign pc_plus4       = pc_q + 32'd4;   // 32-bit wrap is intended
  assign target_aligned = PCTarget & PC_ALIGN;

  // A bubble in IF/ID can always be overwritten, so StallD only matters when ValidD is set.
  assign accept = !StallD || !valid_q;

  // Fetch FSM: next state, PC update, request outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    skid_d    = skid_q;
    load      = 1'b0;
    load_word = imem_rdata;
    imem_req  = 1'b0;
    imem_addr = pc_q;

    case (state_q)
      S_REQ: begin
        imem_req = !rst;
        if (PCSrc) begin
          pc_d = target_aligned;
          // A request accepted in the redirect cycle is for the old PC and must be thrown away.
          if (imem_ready) state_d = S_DROP;
        end else if (imem_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (PCSrc) begin
          pc_d    = target_aligned;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (accept) begin
            load      = 1'b1;
            load_word = imem_rdata;
            pc_d      = pc_plus4;
            state_d   = S_REQ;
          end else begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (PCSrc) begin
          pc_d    = target_aligned;
          state_d = S_REQ;
        end else if (accept) begin
          load      = 1'b1;
          load_word = skid_q;
          pc_d      = pc_plus4;
          state_d   = S_REQ;
        end
      end

      S_DROP: begin
        if (PCSrc) pc_d = target_aligned;
        if (imem_rvalid) state_d = S_REQ;
      end

      default: state_d = S_REQ;
    endcase
  end

  // IF/ID register: flush beats load, load beats hold, otherwise insert a bubble.
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    if (PCSrc) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_word;
      pcd_d   = pc_q;
      pc4_d   = pc_plus4;
    end else if (StallD && valid_q) begin
      valid_d = valid_q;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC & PC_ALIGN;
      skid_q  <= 32'h0;
      instr_q <= NOP;
      pcd_q   <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pc4_q;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : self-checking bench for fetch_stage against a transaction-level fetch-stream model.
// Latency : checks registered outputs #1 after each rising edge, bus outputs mid-cycle.
// Backpressure: drives random StallD, imem_ready and response latency.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] DATA_OFS = 32'h0000_0100;  // memory returns addr + 0x100

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = 32'h0;
  logic        StallD = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .StallD     (StallD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: one pending request, response after a random latency.
  bit          pend = 1'b0;
  bit          pend_sq = 1'b0;     // pending request belongs to a squashed path
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  int          ready_pct = 100;
  int          ready_low = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // Fetch-stream model: the next PC the program expects, and the IF/ID contents it should see.
  bit          avail = 1'b0;       // a good word has arrived but decode has not taken it yet
  logic [31:0] exp_pc = RESET_PC;
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pcd = 32'h0;
  logic [31:0] m_pc4 = 32'h0;
  int          loads = 0;

  logic        req_s = 1'b0;
  logic [31:0] addr_s = 32'h0;
  bit          prev_hold_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic bit resp_due();
    return pend && (pend_cnt == 0);
  endfunction

  task automatic cycle(input bit r, input bit pcsrc, input logic [31:0] tgt, input bit stall);
    bit rv, rdy, acc, accept, good, load, busy;
    rv   = resp_due() && !r;
    busy = pend || avail;
    if (ready_low > 0) begin
      rdy = 1'b0;
      ready_low--;
    end else begin
      rdy = ($urandom_range(0, 99) < ready_pct);
    end
    rst         = r;
    PCSrc       = pcsrc;
    PCTarget    = tgt;
    StallD      = stall;
    imem_ready  = rdy;
    imem_rvalid = rv;
    imem_rdata  = rv ? pend_addr + DATA_OFS : $urandom;
    #3;
    req_s  = imem_req;
    addr_s = imem_addr;
    if (r) begin
      check("req_in_rst", 32'(req_s), 32'd0);
    end else if (prev_hold_req) begin
      check("req_stable", 32'(req_s), 32'd1);
      check("addr_stable", addr_s, prev_addr);
    end
    prev_hold_req = req_s && !rdy && !pcsrc && !r;
    prev_addr     = addr_s;

    @(posedge clk);
    #1;
    acc = req_s && rdy && !r;
    if (r) begin
      pend = 1'b0; pend_sq = 1'b0; avail = 1'b0;
      exp_pc = RESET_PC;
      m_valid = 1'b0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0;
    end else begin
      accept = !stall || !m_valid;
      load   = 1'b0;
      if (rv) begin
        good = !pend_sq && !pcsrc;
        pend = 1'b0;
        if (good && accept) load = 1'b1;
        else if (good) avail = 1'b1;
      end else if (avail) begin
        if (pcsrc) avail = 1'b0;
        else if (accept) begin load = 1'b1; avail = 1'b0; end
      end else if (pend) begin
        pend_cnt--;
        if (pcsrc) pend_sq = 1'b1;
      end
      if (acc) begin
        check("one_outstanding", 32'(busy), 32'd0);
        if (!pcsrc) check("req_addr", addr_s, exp_pc);
        pend      = 1'b1;
        pend_sq   = pcsrc;
        pend_addr = addr_s;
        pend_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
      end
      if (pcsrc) begin
        m_valid = 1'b0; m_instr = NOP;
        exp_pc  = tgt & 32'hFFFF_FFFC;
      end else if (load) begin
        m_valid = 1'b1;
        m_instr = exp_pc + DATA_OFS;
        m_pcd   = exp_pc;
        m_pc4   = exp_pc + 32'd4;
        exp_pc  = exp_pc + 32'd4;
        loads++;
      end else if (!(stall && m_valid)) begin
        m_valid = 1'b0; m_instr = NOP;
      end
    end
    check("ValidD", 32'(ValidD), 32'(m_valid));
    check("InstrD", InstrD, m_instr);
    if (m_valid || r) begin
      check("PCD", PCD, m_pcd);
      check("PCPlus4D", PCPlus4D, m_pc4);
    end
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    while (ValidD !== 1'b1 && n < limit) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end
    if (ValidD !== 1'b1) check(tag, 32'(ValidD), 32'd1);
  endtask

  initial begin
    int loads_before;
    bit r, pc, st;
    logic [31:0] tgt;

    // Reset, zero-wait memory.
    ready_pct = 100; lat_min = 1; lat_max = 1;
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("rst_InstrD", InstrD, NOP);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("first_req", 32'(req_s), 32'd1);
    check("first_addr", addr_s, RESET_PC);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("first_ValidD", 32'(ValidD), 32'd1);
    check("first_InstrD", InstrD, 32'h100);
    check("first_PCPlus4D", PCPlus4D, 32'h4);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("second_InstrD", InstrD, 32'h104);
    check("second_PCD", PCD, 32'h4);

    // imem_ready low for three cycles while requesting 0x8.
    ready_low = 3;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      check("wait_req", 32'(req_s), 32'd1);
      check("wait_addr", addr_s, 32'h8);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("ready_low_PCD", PCD, 32'h8);

    // Stall four cycles: word for 0xC parks in the skid buffer.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check("stall_hold_PCD", PCD, 32'h8);
      if (i >= 2) check("hold_no_req", 32'(req_s), 32'd0);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("skid_PCD", PCD, 32'hC);
    check("skid_InstrD", InstrD, 32'h10C);

    // Redirect while waiting with no response yet.
    lat_min = 3; lat_max = 3;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    check("flush_ValidD", 32'(ValidD), 32'd0);
    wait_valid("redirect_timeout", 20);
    check("redirect_PCD", PCD, 32'h40);

    // Redirect coincident with the response in WAIT.
    lat_min = 1; lat_max = 1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("resp_due", 32'(resp_due()), 32'd1);
    cycle(1'b0, 1'b1, 32'h80, 1'b0);
    check("coinc_InstrD", InstrD, NOP);
    wait_valid("coinc_timeout", 20);
    check("coinc_PCD", PCD, 32'h80);

    // Redirect while a word sits in the skid buffer.
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'hC0, 1'b1);
    check("hold_flush_ValidD", 32'(ValidD), 32'd0);
    wait_valid("hold_timeout", 20);
    check("hold_redirect_PCD", PCD, 32'hC0);

    // PC wrap at the top of the address space (low target bits are ignored).
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    wait_valid("wrap_timeout", 20);
    check("wrap_PCD", PCD, 32'hFFFF_FFFC);
    check("wrap_PCPlus4D", PCPlus4D, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_next_addr", addr_s, 32'h0);

    // Reset in the middle of WAIT.
    cycle(1'b0, 1'b1, 32'h200, 1'b0);
    wait_valid("pre_rst_timeout", 20);
    lat_min = 3; lat_max = 3;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("midrst_ValidD", 32'(ValidD), 32'd0);
    check("midrst_InstrD", InstrD, NOP);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check("midrst_req", 32'(req_s), 32'd1);
    check("midrst_addr", addr_s, RESET_PC);

    // Random traffic.
    ready_pct = 70; lat_min = 1; lat_max = 3;
    loads_before = loads;
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      pc  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 2) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                        : 32'($urandom_range(0, 32'h000F_FFFF));
      cycle(r, pc, tgt, st);
    end
    check("progress", 32'((loads - loads_before) >= 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32I pipeline. It owns the PC register and issues instruction-memory reads over a single-outstanding request/response handshake. It registers each returned word, its PC and PC+4 into the IF/ID register, which feeds the decode stage (control unit and immediate sign extender). The block also absorbs decode stalls and squashes wrong-path fetches on a taken branch or jump.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- PCSrc  in  1  taken branch/jump redirect from execute; also flushes IF/ID
- PCTarget  in  32  redirect target, valid when PCSrc=1
- StallD  in  1  decode not accepting; IF/ID must hold
- imem_req  out  1  read request
- imem_addr  out  32  read address (word aligned)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid; in order, at most one outstanding
- imem_rdata  in  32  instruction word
- InstrD  out  32  IF/ID instruction
- PCD  out  32  IF/ID PC
- PCPlus4D  out  32  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction

## Operation
- PC register always holds the address of the current or next fetch. PC[1:0] is forced to 0 on every load.
- FSM states and IF/ID loading:
  - REQ:
    - imem_req=1, imem_addr=PC.
    - PCSrc: PC<=PCTarget. If imem_ready in the same cycle, go to DROP; otherwise stay in REQ.
    - imem_ready && !PCSrc: go to WAIT.
  - WAIT:
    - imem_req=0.
    - PCSrc: PC<=PCTarget. With imem_rvalid the response is discarded and the FSM goes to REQ; without it, go to DROP.
    - imem_rvalid && accept: load IF/ID, PC<=PC+4, go to REQ.
    - imem_rvalid && !accept: capture imem_rdata in the skid buffer, go to HOLD.
  - HOLD:
    - imem_req=0.
    - PCSrc: discard the buffer, PC<=PCTarget, go to REQ.
    - accept: load IF/ID from the buffer, PC<=PC+4, go to REQ.
  - DROP:
    - imem_req=0.
    - Waits for the stale response. On imem_rvalid, discard it and go to REQ.
    - PCSrc: PC<=PCTarget, stay in DROP.
  - accept = !StallD || !ValidD. A bubble may always be overwritten.
  - IF/ID load: InstrD<=word, PCD<=PC, PCPlus4D<=PC+4, ValidD<=1. Addition is 32-bit with wrap (32'hFFFF_FFFC+4=0).
- IF/ID priority, highest first:
  - rst
  - PCSrc (flush): ValidD<=0, InstrD<=32'h0000_0013 (NOP)
  - load
  - StallD && ValidD: hold all fields
  - otherwise bubble: ValidD<=0, InstrD<=NOP, PCD/PCPlus4D hold
- Reset values:
  - PC=RESET_PC, state=REQ
  - ValidD=0, InstrD=32'h0000_0013, PCD=0, PCPlus4D=0
  - imem_req forced 0 while rst=1
- Invariants:
  - Never more than one request outstanding.
  - imem_addr is stable while imem_req=1 and imem_ready=0, except on PCSrc.
  - A squashed response never reaches IF/ID.

## Timing
- imem_req, imem_addr, and the accept decision are combinational from state/PC/inputs. All other outputs are registered.
- Best case (imem_ready=1, rvalid one cycle after acceptance):
  - request accepted in cycle N
  - rvalid in N+1
  - ValidD=1 and next request in N+2
  - steady-state throughput one instruction per 2 cycles
- PCSrc in cycle N: ValidD=0 in N+1. First request to PCTarget no later than N+1 (REQ/WAIT/HOLD) or the cycle after the stale rvalid (DROP).
- rst asserted mid-operation: state returns to REQ at RESET_PC. A response outstanding at reset is the memory's responsibility; the memory must also be reset.
- StallD is ignored while ValidD=0.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning addr+0x100 as data: ValidD first high 2 cycles after rst drops with InstrD=0x100, PCD=0, PCPlus4D=4; next word has InstrD=0x104, PCD=4.
- imem_ready low for 3 cycles: imem_req stays 1 and imem_addr stays 0x8 throughout; single acceptance; IF/ID gets PCD=0x8.
- StallD held 4 cycles with ValidD=1 and rvalid arriving: IF/ID unchanged; FSM goes to HOLD and no new request issues; after release the buffered word loads next cycle with correct PC.
- PCSrc=1, PCTarget=0x40 while in WAIT with no rvalid: ValidD=0 next cycle; the later stale rvalid is discarded; next imem_addr=0x40; first valid PCD=0x40.
- PCSrc coincident with imem_rvalid in WAIT, and separately PCSrc in HOLD: the word never appears on InstrD; next request goes to the target.
- PC=0xFFFF_FFFC fetch: PCPlus4D=0 and next imem_addr=0. Also assert rst mid-WAIT: ValidD=0, InstrD=0x13, next imem_addr=RESET_PC.
